// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared definitions for the run-control block:
//   - state_t   : run-control FSM state encoding
//   - ALL_ONES  : wide all-ones constant; the top slices it down to its counter
//                 width to get the saturation value (counters up to 64 bits)
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RST   = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int                  CNT_W_MAX = 64;
   localparam logic [CNT_W_MAX-1:0] ALL_ONES = '1;

endpackage

// File: rtl/run_ctrl_rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
// Two-flop reset synchronizer: asserts asynchronously with iRst, deasserts
// synchronously two iClk edges after iRst falls.
// Ports:
//   iClk      system clock
//   iRst      asynchronous active-high reset in
//   oSyncRst  synchronized active-high reset out
// -----------------------------------------------------------------------------
module rst_sync (
   input  logic iClk,
   input  logic iRst,
   output logic oSyncRst
);

   logic meta_q;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         meta_q   <= 1'b1;
         oSyncRst <= 1'b1;
      end else begin
         meta_q   <= 1'b0;
         oSyncRst <= meta_q;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Run control for the multicycle core: sequences the core reset release,
// drives the core clock-enable, counts executed cycles, enforces a watchdog
// limit and drains the core for a few cycles after a halt request.
//
// Optional feature macro: RUN_CTRL_KICK_EN adds iKick, which restarts the
// watchdog count while running.
//
// Ports:
//   iClk        system clock
//   iRst        asynchronous active-high reset
//   iHalt       halt request from the core, only looked at while running
//   iRestart    one-cycle pulse; restarts the reset sequence from S_DONE
//   iKick       (RUN_CTRL_KICK_EN only) clears the watchdog while running
//   oCoreRst_n  active-low reset to the core
//   oCoreEn     clock-enable to the core
//   oCycles     cycles spent in S_RUN/S_DRAIN, saturating
//   oHalted     sticky: halt accepted
//   oTimeout    sticky: watchdog expired
//   oDone       sticky: core stopped
//   oState      current FSM state (debug)
//
// Handshake: there is no valid/ready pair here; iHalt is a level sampled on
// every S_RUN clock, iRestart/iKick are single-cycle pulses acted on only in
// the state that honours them and silently dropped elsewhere.
// -----------------------------------------------------------------------------
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 625,
   parameter int HALT_DRAIN = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iHalt,
   input  logic             iRestart,
`ifdef RUN_CTRL_KICK_EN
   input  logic             iKick,
`endif
   output logic             oCoreRst_n,
   output logic             oCoreEn,
   output logic [CNT_W-1:0] oCycles,
   output logic             oHalted,
   output logic             oTimeout,
   output logic             oDone,
   output state_t           oState
);

   localparam logic [CNT_W-1:0] CNT_ONES   = ALL_ONES[CNT_W-1:0];
   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((HALT_DRAIN > 0) ? HALT_DRAIN - 1 : 0);
   localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);
   localparam bit               WD_EN      = (MAX_CYCLES != 0);
   localparam bit               NO_DRAIN   = (HALT_DRAIN == 0);

   logic             sync_rst;
   logic             kick;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] seq_q, seq_d;   // reset-sequence length, then drain length
   logic [CNT_W-1:0] wd_q, wd_d;
   logic [CNT_W-1:0] cyc_d;
   logic             halted_d, timeout_d;

`ifdef RUN_CTRL_KICK_EN
   assign kick = iKick;
`else
   assign kick = 1'b0;
`endif

   rst_sync u_rst_sync (
      .iClk     (iClk),
      .iRst     (iRst),
      .oSyncRst (sync_rst)
   );

   assign oState = state_q;

   // While the synchronizer still holds reset the block sits at its reset
   // values; the sequence counter starts on the first edge after it drops.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q    <= S_RST;
         seq_q      <= '0;
         wd_q       <= '0;
         oCycles    <= '0;
         oHalted    <= 1'b0;
         oTimeout   <= 1'b0;
         oDone      <= 1'b0;
         oCoreRst_n <= 1'b0;
         oCoreEn    <= 1'b0;
      end else if (sync_rst) begin
         state_q    <= S_RST;
         seq_q      <= '0;
         wd_q       <= '0;
         oCycles    <= '0;
         oHalted    <= 1'b0;
         oTimeout   <= 1'b0;
         oDone      <= 1'b0;
         oCoreRst_n <= 1'b0;
         oCoreEn    <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         wd_q       <= wd_d;
         oCycles    <= cyc_d;
         oHalted    <= halted_d;
         oTimeout   <= timeout_d;
         // Outputs decoded from the next state so they line up with it.
         oCoreRst_n <= (state_d != S_RST);
         oCoreEn    <= (state_d == S_RUN) || (state_d == S_DRAIN);
         oDone      <= (state_d == S_DONE);
      end
   end

   always_comb begin
      state_d   = state_q;
      seq_d     = seq_q;
      wd_d      = wd_q;
      cyc_d     = oCycles;
      halted_d  = oHalted;
      timeout_d = oTimeout;

      case (state_q)
         S_RST: begin
            if (seq_q == RST_LAST) begin
               state_d = S_RUN;
               seq_d   = '0;
            end else begin
               seq_d = seq_q + 1'b1;
            end
         end

         S_RUN: begin
            cyc_d = (oCycles == CNT_ONES) ? oCycles : oCycles + 1'b1;
            // Halt beats both kick and watchdog expiry in the same cycle.
            if (iHalt) begin
               halted_d = 1'b1;
               seq_d    = '0;
               state_d  = NO_DRAIN ? S_DONE : S_DRAIN;
            end else if (kick) begin
               wd_d = '0;
            end else if (WD_EN && (wd_q == WD_LAST)) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               wd_d = (wd_q == CNT_ONES) ? wd_q : wd_q + 1'b1;
            end
         end

         S_DRAIN: begin
            cyc_d = (oCycles == CNT_ONES) ? oCycles : oCycles + 1'b1;
            if (seq_q == DRAIN_LAST) begin
               state_d = S_DONE;
               seq_d   = '0;
            end else begin
               seq_d = seq_q + 1'b1;
            end
         end

         S_DONE: begin
            if (iRestart) begin
               state_d   = S_RST;
               seq_d     = '0;
               wd_d      = '0;
               cyc_d     = '0;
               halted_d  = 1'b0;
               timeout_d = 1'b0;
            end
         end

         default: state_d = S_RST;
      endcase
   end

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
// Two instances share one stimulus stream:
//   u0 : default parameters (RST_CYCLES=2, CNT_W=32, MAX_CYCLES=625, HALT_DRAIN=4)
//   u1 : RST_CYCLES=1, CNT_W=4, MAX_CYCLES=0, HALT_DRAIN=0 (saturation, no
//        watchdog, halt straight to done)
// A timeline model of each instance is advanced on every clock edge and every
// output of both instances is compared against it on each falling edge.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic halt = 1'b0;
   logic restart = 1'b0;
   logic kick = 1'b0;

   always #5 clk = ~clk;

   // ---------------- DUT outputs ----------------
   logic        rst_n_o[2];
   logic        en_o[2];
   logic        halted_o[2];
   logic        to_o[2];
   logic        done_o[2];
   logic [31:0] cyc0;
   logic [3:0]  cyc1;
   logic [63:0] cyc_o[2];
   run_ctrl_pkg::state_t st0, st1;

   assign cyc_o[0] = {32'b0, cyc0};
   assign cyc_o[1] = {60'b0, cyc1};

   run_ctrl u0 (
      .iClk       (clk),
      .iRst       (rst),
      .iHalt      (halt),
      .iRestart   (restart),
`ifdef RUN_CTRL_KICK_EN
      .iKick      (kick),
`endif
      .oCoreRst_n (rst_n_o[0]),
      .oCoreEn    (en_o[0]),
      .oCycles    (cyc0),
      .oHalted    (halted_o[0]),
      .oTimeout   (to_o[0]),
      .oDone      (done_o[0]),
      .oState     (st0)
   );

   run_ctrl #(
      .RST_CYCLES (1),
      .CNT_W      (4),
      .MAX_CYCLES (0),
      .HALT_DRAIN (0)
   ) u1 (
      .iClk       (clk),
      .iRst       (rst),
      .iHalt      (halt),
      .iRestart   (restart),
`ifdef RUN_CTRL_KICK_EN
      .iKick      (kick),
`endif
      .oCoreRst_n (rst_n_o[1]),
      .oCoreEn    (en_o[1]),
      .oCycles    (cyc1),
      .oHalted    (halted_o[1]),
      .oTimeout   (to_o[1]),
      .oDone      (done_o[1]),
      .oState     (st1)
   );

   // ---------------- per-instance parameters ----------------
   function automatic int p_rst(int i);
      return (i == 0) ? 2 : 1;
   endfunction
   function automatic longint p_max(int i);
      return (i == 0) ? 64'd625 : 64'd0;
   endfunction
   function automatic int p_hd(int i);
      return (i == 0) ? 4 : 0;
   endfunction
   function automatic longint p_cmax(int i);
      return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
   endfunction

   // ---------------- reference model ----------------
   // Timeline view: edges since reset release, edges in the release sequence,
   // then a run that ends either by halt (+ drain) or by the watchdog.
   int     m_sync[2];
   int     m_seq[2];
   int     m_drain[2];
   bit     m_rel[2];
   bit     m_done[2];
   bit     m_halted[2];
   bit     m_to[2];
   longint m_cyc[2];
   longint m_wd[2];

   task automatic model_clear(int i);
      m_seq[i]    = 0;
      m_drain[i]  = 0;
      m_rel[i]    = 1'b0;
      m_done[i]   = 1'b0;
      m_halted[i] = 1'b0;
      m_to[i]     = 1'b0;
      m_cyc[i]    = 0;
      m_wd[i]     = 0;
   endtask

   task automatic model_step(int i);
      if (m_sync[i] < 2) begin
         m_sync[i]++;
         return;
      end
      if (!m_rel[i]) begin
         m_seq[i]++;
         if (m_seq[i] == p_rst(i)) m_rel[i] = 1'b1;
         return;
      end
      if (m_done[i]) begin
         if (restart) model_clear(i);
         return;
      end
      if (m_cyc[i] < p_cmax(i)) m_cyc[i]++;
      if (m_drain[i] > 0) begin
         m_drain[i]--;
         if (m_drain[i] == 0) m_done[i] = 1'b1;
         return;
      end
      if (halt) begin
         m_halted[i] = 1'b1;
         if (p_hd(i) == 0) m_done[i] = 1'b1;
         else m_drain[i] = p_hd(i);
      end else if (kick) begin
         m_wd[i] = 0;
      end else begin
         m_wd[i]++;
         if (p_max(i) != 0 && m_wd[i] == p_max(i)) begin
            m_to[i]   = 1'b1;
            m_done[i] = 1'b1;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_sync[i] = 0;
            model_clear(i);
         end else begin
            model_step(i);
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d.oCoreRst_n", i), 64'(rst_n_o[i]), 64'(m_rel[i]));
         check($sformatf("u%0d.oCoreEn", i), 64'(en_o[i]), 64'(m_rel[i] && !m_done[i]));
         check($sformatf("u%0d.oCycles", i), cyc_o[i], m_cyc[i]);
         check($sformatf("u%0d.oHalted", i), 64'(halted_o[i]), 64'(m_halted[i]));
         check($sformatf("u%0d.oTimeout", i), 64'(to_o[i]), 64'(m_to[i]));
         check($sformatf("u%0d.oDone", i), 64'(done_o[i]), 64'(m_done[i]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      next_cycle();
      restart = 1'b0;
   endtask

   task automatic wait_cyc0(int value, int budget);
      int n = 0;
      while (cyc0 != 32'(value) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("reach_oCycles_%0d", value), {32'b0, cyc0}, 64'(value));
      #1;
   endtask

   task automatic wait_done0(int budget);
      int n = 0;
      while (!done_o[0] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("reach_oDone", 64'(done_o[0]), 64'd1);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      #2 rst = 1'b1;
      @(negedge clk);
      check("reset.oCoreRst_n", 64'(rst_n_o[0]), 64'd0);
      check("reset.oCoreEn", 64'(en_o[0]), 64'd0);
      check("reset.oCycles", {32'b0, cyc0}, 64'd0);
      check("reset.oDone", 64'(done_o[0]), 64'd0);
      #1 rst = 1'b0;

      // Reset release: oCoreRst_n low through edge 3, high after edge 4.
      repeat (3) @(negedge clk);
      check("release.rst_n_after_edge3", 64'(rst_n_o[0]), 64'd0);
      @(negedge clk);
      check("release.rst_n_after_edge4", 64'(rst_n_o[0]), 64'd1);
      check("release.en_after_edge4", 64'(en_o[0]), 64'd1);
      check("release.cycles_after_edge4", {32'b0, cyc0}, 64'd0);
      #1;

      // Halt with drain at oCycles=10.
      wait_cyc0(10, 50);
      halt = 1'b1;
      @(negedge clk);
      check("halt.oHalted", 64'(halted_o[0]), 64'd1);
      check("halt.en_0", 64'(en_o[0]), 64'd1);
      #1 halt = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("halt.en_%0d", k), 64'(en_o[0]), 64'd1);
      end
      @(negedge clk);
      check("halt.oDone", 64'(done_o[0]), 64'd1);
      check("halt.oCycles", {32'b0, cyc0}, 64'd15);
      check("halt.oTimeout", 64'(to_o[0]), 64'd0);
      check("halt.en_off", 64'(en_o[0]), 64'd0);
      #1;

      // Restart: core reset low two cycles, everything cleared.
      pulse_restart();
      check("restart.rst_n_0", 64'(rst_n_o[0]), 64'd0);
      check("restart.cycles", {32'b0, cyc0}, 64'd0);
      check("restart.halted", 64'(halted_o[0]), 64'd0);
      check("restart.done", 64'(done_o[0]), 64'd0);
      @(negedge clk);
      check("restart.rst_n_1", 64'(rst_n_o[0]), 64'd0);
      @(negedge clk);
      check("restart.rst_n_2", 64'(rst_n_o[0]), 64'd1);
      #1;

      // Watchdog: no halt, expires at oCycles=625 and stays put.
      wait_done0(800);
      check("wd.oTimeout", 64'(to_o[0]), 64'd1);
      check("wd.oCycles", {32'b0, cyc0}, 64'd625);
      check("wd.en_off", 64'(en_o[0]), 64'd0);
      check("sat.u1_oCycles", {60'b0, cyc1}, 64'd15);
      repeat (100) next_cycle();
      check("wd.sticky_timeout", 64'(to_o[0]), 64'd1);
      check("wd.sticky_cycles", {32'b0, cyc0}, 64'd625);

      // Halt on the same cycle the watchdog would expire.
      pulse_restart();
      wait_cyc0(624, 800);
      halt = 1'b1;
      @(negedge clk);
      check("simul.oHalted", 64'(halted_o[0]), 64'd1);
      check("simul.oTimeout", 64'(to_o[0]), 64'd0);
      #1 halt = 1'b0;
      wait_done0(20);
      check("simul.oCycles", {32'b0, cyc0}, 64'd629);
      check("simul.oTimeout_final", 64'(to_o[0]), 64'd0);

      // Reset asserted during drain aborts at once.
      pulse_restart();
      wait_cyc0(5, 50);
      halt = 1'b1;
      next_cycle();
      halt = 1'b0;
      rst = 1'b1;
      #1;
      check("abort.rst_n", 64'(rst_n_o[0]), 64'd0);
      check("abort.en", 64'(en_o[0]), 64'd0);
      check("abort.cycles", {32'b0, cyc0}, 64'd0);
      check("abort.halted", 64'(halted_o[0]), 64'd0);
      check("abort.done", 64'(done_o[0]), 64'd0);
      next_cycle();
      rst = 1'b0;
      repeat (3) next_cycle();
      check("abort.no_done", 64'(done_o[0]), 64'd0);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         halt    = ($urandom_range(0, 59) == 0);
         restart = ($urandom_range(0, 3) == 0);
`ifdef RUN_CTRL_KICK_EN
         kick    = ($urandom_range(0, 2) == 0);
`endif
         rst     = ($urandom_range(0, 799) == 0);
         next_cycle();
      end
      halt    = 1'b0;
      restart = 1'b0;
      kick    = 1'b0;
      rst     = 1'b0;
      repeat (4) next_cycle();

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run-control block for the multicycle core.
- Generates the core's reset release and a clock-enable.
- Counts executed cycles, enforces a watchdog cycle limit and drains the core after a halt request.
- Sits between the board/bench reset and the core's clock and reset inputs; reports done or timeout to the bench or board LEDs.

Parameters:
RST_CYCLES, 2, cycles oCoreRst_n is held low after synchronized reset release (>=1)
CNT_W, 32, width of cycle and watchdog counters
MAX_CYCLES, 625, watchdog limit in cycles; 0 disables watchdog
HALT_DRAIN, 4, cycles the core stays enabled after iHalt before stopping (0 allowed)

Ports:
iClk  input  1  system clock
iRst  input  1  asynchronous, active-high reset
iHalt  input  1  halt request from core (e.g. break decoded), sampled in S_RUN only
iRestart  input  1  single-cycle pulse; restarts reset sequence, honoured in S_DONE only
oCoreRst_n  output  1  active-low reset to core
oCoreEn  output  1  clock-enable to core
oCycles  output  CNT_W  cycles spent in S_RUN and S_DRAIN; saturates at all-ones
oHalted  output  1  halt was accepted (sticky until reset/restart)
oTimeout  output  1  watchdog expired (sticky until reset/restart)
oDone  output  1  core stopped (sticky until reset/restart)

Behaviour:
- iRst high: all flops cleared immediately (asynchronously). State=S_RST; oCoreRst_n=0, oCoreEn=0, oCycles=0, oHalted=0, oTimeout=0, oDone=0.
- iRst release: asserted asynchronously, deasserted through a 2-flop synchronizer. Counting starts the cycle after the synchronizer output falls.
- S_RST: rst counter increments each cycle. At count RST_CYCLES-1, go to S_RUN. oCoreRst_n is registered high from the first S_RUN cycle.
- Reset-release timing example: iRst falls before edge 1 and RST_CYCLES=2; oCoreRst_n rises after edge 4.
- S_RUN:
  - oCoreEn=1; oCycles and watchdog counter +1 per cycle.
  - iHalt=1: go to S_DRAIN (or S_DONE if HALT_DRAIN=0) and set oHalted.
  - Else, watchdog==MAX_CYCLES-1 with MAX_CYCLES!=0: go to S_DONE and set oTimeout.
  - iHalt and watchdog expiry in the same cycle: halt wins; oTimeout stays 0.
- S_DRAIN: oCoreEn=1 and oCycles keeps counting for exactly HALT_DRAIN cycles, then S_DONE. Watchdog is ignored and iHalt is ignored.
- S_DONE: oCoreEn=0, oDone=1, oCycles frozen; oCoreRst_n stays 1 so core state remains inspectable.
- iRestart in S_DONE: next state S_RST. oCoreRst_n=0, and all counters and flags clear on the same edge. iRestart in any other state: no effect.
- oCycles saturation: at all-ones it holds its value and does not wrap; the watchdog still fires if MAX_CYCLES is reachable.
- Mid-operation reset: iRst asserted in any state aborts immediately to reset values; no drain occurs.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
RUN_CTRL_KICK_EN
- Defined:
  - Adds input iKick (1 bit). iKick=1 in S_RUN clears the watchdog counter to 0 on that edge; oCycles is unaffected.
  - Watchdog therefore measures cycles since the last kick.
  - Kick and halt in the same cycle: halt wins.
- Undefined: no iKick port; watchdog equals total cycles in S_RUN.

Decomposition:
- Package run_ctrl_pkg:
  - state encoding S_RST=2'd0, S_RUN=2'd1, S_DRAIN=2'd2, S_DONE=2'd3.
  - Helper constant for counter all-ones.
- Sub-module rst_sync: 2-flop async-assert/sync-deassert synchronizer, instantiated once.

Test Plan:
- Reset release: defaults; pulse iRst 1 cycle -> oCoreRst_n=0 through edge 4, =1 after edge 4; oCoreEn=1 same cycle; oCycles=0 then increments.
- Halt with drain: iHalt=1 when oCycles=10 -> oHalted=1 next edge; oCoreEn high 4 more cycles; oDone=1 with oCycles=15, oTimeout=0.
- Watchdog: iHalt tied 0 -> oTimeout=1, oDone=1 when oCycles=625; oCoreEn=0 thereafter; remains sticky 100 cycles.
- Simultaneous: iHalt=1 on the cycle oCycles=624 -> oHalted=1, oTimeout=0, drain completes, oDone=1 at oCycles=629.
- Restart and mid-run reset:
  - iRestart in S_DONE -> oCoreRst_n low 2 cycles, flags and counters cleared, run resumes.
  - iRst asserted during S_DRAIN -> all outputs 0 immediately, no oDone.
- Kick (RUN_CTRL_KICK_EN): MAX_CYCLES=8, iKick every 5 cycles for 40 cycles -> no timeout; kicks stop at oCycles=40 -> oTimeout=1 at oCycles=48.
